// File: rtl/fp_mul_div_seq.sv
// fp_mul_div_seq: sequential IEEE-754-style multiply/divide, one op in flight, RNE rounding.
// Define FP_STICKY_FLAGS_EN to add flag_clr / sticky_flags accumulation across results.
module fp_mul_div_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         en,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sel,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] R,
    output logic         io_flag,
    output logic         dz_flag,
    output logic         of_flag,
    output logic         uf_flag,
    output logic         i_flag,
`ifdef FP_STICKY_FLAGS_EN
    input  logic         flag_clr,
    output logic [4:0]   sticky_flags,
`endif
    output logic [2:0]   dbg_state
);
    // Handshakes: a transfer occurs on a rising edge where valid && ready && en are all high;
    // the source holds valid and data stable until that edge.
    localparam int BIAS = 2**(EXP_W-1) - 1;
    localparam int PW = 2*MAN_W + 2;
    localparam int QW = MAN_W + 4;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(QW + 1);
    localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
    localparam logic signed [EW-1:0] EMAX_S = EW'(2**EXP_W - 1);
    localparam logic signed [EW-1:0] ONE_S  = EW'(1);
    localparam logic signed [EW-1:0] ZERO_S = '0;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MUL, S_DIV, S_NORM, S_ROUND, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [W-1:0]           a_q, a_d, b_q, b_d, r_q, r_d;
    logic                   sel_q, sel_d, sign_q, sign_d, special_q, special_d;
    logic [PW-1:0]          prod_q, prod_d;
    logic [QW-1:0]          quo_q, quo_d;
    logic [MAN_W+1:0]       rem_q, rem_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic signed [EW-1:0]   exp_q, exp_d;
    logic [MAN_W:0]         sig_q, sig_d;
    logic [2:0]             grs_q, grs_d;
    logic [4:0]             flags_q, flags_d;

    logic [EXP_W-1:0]       ea, eb;
    logic [MAN_W-1:0]       ma, mb;
    logic [MAN_W:0]         sig_a, sig_b;
    logic                   nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, snan_a, snan_b, res_sign;
    logic signed [EW-1:0]   ea_s, eb_s, exp_r;
    logic                   div_ge, rinc;
    logic [MAN_W+1:0]       div_diff, msum;
    logic [PW-1:0]          pn;
    logic [QW-1:0]          qn;
    logic [MAN_W-1:0]       frac;

    // Subnormals (exp field 0) are treated as zero throughout.
    assign ea       = a_q[W-2 -: EXP_W];
    assign eb       = b_q[W-2 -: EXP_W];
    assign ma       = a_q[MAN_W-1:0];
    assign mb       = b_q[MAN_W-1:0];
    assign nan_a    = (&ea) & (|ma);
    assign nan_b    = (&eb) & (|mb);
    assign inf_a    = (&ea) & ~(|ma);
    assign inf_b    = (&eb) & ~(|mb);
    assign zero_a   = ~(|ea);
    assign zero_b   = ~(|eb);
    assign snan_a   = nan_a & ~ma[MAN_W-1];
    assign snan_b   = nan_b & ~mb[MAN_W-1];
    assign sig_a    = {1'b1, ma};
    assign sig_b    = {1'b1, mb};
    assign res_sign = a_q[W-1] ^ b_q[W-1];
    assign ea_s     = $signed({2'b00, ea});
    assign eb_s     = $signed({2'b00, eb});

    assign div_ge   = rem_q >= {1'b0, sig_b};
    assign div_diff = div_ge ? rem_q - {1'b0, sig_b} : rem_q;

    // Left-align product/quotient so the leading one sits in the MSB; bit 0 fills with zero.
    assign pn = prod_q[PW-1] ? prod_q : {prod_q[PW-2:0], 1'b0};
    assign qn = quo_q[QW-1]  ? quo_q  : {quo_q[QW-2:0], 1'b0};

    assign rinc  = grs_q[2] & (grs_q[1] | grs_q[0] | sig_q[0]);
    assign msum  = {1'b0, sig_q} + {{(MAN_W+1){1'b0}}, rinc};
    assign exp_r = exp_q + (msum[MAN_W+1] ? ONE_S : ZERO_S);
    assign frac  = msum[MAN_W+1] ? msum[MAN_W:1] : msum[MAN_W-1:0];

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sel_d     = sel_q;
        sign_d    = sign_q;
        special_d = special_q;
        prod_d    = prod_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        exp_d     = exp_q;
        sig_d     = sig_q;
        grs_d     = grs_q;
        r_d       = r_q;
        flags_d   = flags_q;
        if (en) begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sel_d   = sel;
                    state_d = S_UNPACK;
                end
                S_UNPACK: begin
                    sign_d    = res_sign;
                    special_d = 1'b1;
                    state_d   = S_ROUND;
                    flags_d   = '0;
                    rem_d     = {1'b0, sig_a};
                    quo_d     = '0;
                    cnt_d     = '0;
                    exp_d     = sel_q ? ea_s - eb_s + BIAS_S : ea_s + eb_s - BIAS_S;
                    if (nan_a || nan_b) begin
                        r_d     = QNAN;
                        flags_d = {snan_a | snan_b, 4'b0000};
                    end else if (!sel_q) begin
                        if ((zero_a && inf_b) || (inf_a && zero_b)) begin
                            r_d     = QNAN;
                            flags_d = 5'b10000;
                        end else if (inf_a || inf_b) begin
                            r_d = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        end else if (zero_a || zero_b) begin
                            r_d = {res_sign, {(W-1){1'b0}}};
                        end else begin
                            special_d = 1'b0;
                            state_d   = S_MUL;
                        end
                    end else begin
                        if ((inf_a && inf_b) || (zero_a && zero_b)) begin
                            r_d     = QNAN;
                            flags_d = 5'b10000;
                        end else if (inf_a) begin
                            r_d = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        end else if (zero_b) begin
                            r_d     = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                            flags_d = 5'b01000;
                        end else if (inf_b || zero_a) begin
                            r_d = {res_sign, {(W-1){1'b0}}};
                        end else begin
                            special_d = 1'b0;
                            state_d   = S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    prod_d  = PW'(sig_a) * PW'(sig_b);
                    state_d = S_NORM;
                end
                // Restoring division: one quotient bit per cycle, first bit is the integer bit.
                S_DIV: begin
                    rem_d = div_diff << 1;
                    quo_d = {quo_q[QW-2:0], div_ge};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(QW-1)) state_d = S_NORM;
                end
                S_NORM: begin
                    if (!sel_q) begin
                        sig_d = pn[PW-1 -: MAN_W+1];
                        grs_d = {pn[PW-MAN_W-2], pn[PW-MAN_W-3], |pn[PW-MAN_W-4:0]};
                        exp_d = exp_q + (prod_q[PW-1] ? ONE_S : ZERO_S);
                    end else begin
                        sig_d = qn[QW-1 -: MAN_W+1];
                        grs_d = {qn[2], qn[1], qn[0] | (|rem_q)};
                        exp_d = exp_q - (quo_q[QW-1] ? ZERO_S : ONE_S);
                    end
                    state_d = S_ROUND;
                end
                S_ROUND: begin
                    if (!special_q) begin
                        if (exp_r >= EMAX_S) begin
                            r_d     = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                            flags_d = 5'b00101;
                        end else if (exp_r <= ZERO_S) begin
                            r_d     = {sign_q, {(W-1){1'b0}}};
                            flags_d = 5'b00011;
                        end else begin
                            r_d     = {sign_q, exp_r[EXP_W-1:0], frac};
                            flags_d = {4'b0000, |grs_q};
                        end
                    end
                    state_d = S_DONE;
                end
                S_DONE: if (out_ready) begin
                    state_d = S_IDLE;
                    flags_d = '0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

`ifdef FP_STICKY_FLAGS_EN
    logic [4:0] sticky_q, sticky_d;
    logic       out_hs;

    assign out_hs = en && (state_q == S_DONE) && out_ready;

    always_comb begin
        sticky_d = sticky_q;
        if (en && flag_clr) sticky_d = out_hs ? flags_q : 5'b00000;
        else if (out_hs)    sticky_d = sticky_q | flags_q;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) sticky_q <= '0;
        else      sticky_q <= sticky_d;
    end

    assign sticky_flags = sticky_q;
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sel_q     <= 1'b0;
            sign_q    <= 1'b0;
            special_q <= 1'b0;
            prod_q    <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            exp_q     <= '0;
            sig_q     <= '0;
            grs_q     <= '0;
            r_q       <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sel_q     <= sel_d;
            sign_q    <= sign_d;
            special_q <= special_d;
            prod_q    <= prod_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            exp_q     <= exp_d;
            sig_q     <= sig_d;
            grs_q     <= grs_d;
            r_q       <= r_d;
            flags_q   <= flags_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) && en;
    assign out_valid = (state_q == S_DONE);
    assign R         = r_q;
    assign {io_flag, dz_flag, of_flag, uf_flag, i_flag} = flags_q;
    assign dbg_state = state_q;

endmodule
